// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared constants and types for the 16-bit processor datapath.
//
//   PC_WIDTH         program counter width in bits
//   PC_STEP          bytes advanced per instruction (16-bit words, byte addressed)
//   PC_RESET_VECTOR  address fetched first after reset
//   pc_t             program counter value type
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned PC_WIDTH = 16;
    localparam int unsigned PC_STEP  = 2;

    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t PC_RESET_VECTOR = 16'h0000;

endpackage : cpu_pkg

// File: rtl/pc_adder.sv
// ---------------------------------------------------------------------------
// pc_adder
//   Combinational next-PC incrementer: sum_o = a_i + STEP, modulo 2**WIDTH.
//   The carry out of the top bit is dropped, so the PC wraps silently.
//
//   Ports
//     a_i    in   WIDTH  current PC
//     sum_o  out  WIDTH  current PC plus STEP
// ---------------------------------------------------------------------------
module pc_adder
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned STEP  = PC_STEP
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] sum_o
);

    // Step narrowed to the datapath width so the add stays WIDTH bits wide
    // and the carry falls off naturally.
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    assign sum_o = a_i + STEP_W;

endmodule : pc_adder

// File: rtl/pc_pc_adder.sv
// ---------------------------------------------------------------------------
// pc_pc_adder
//   Program counter register with built-in incrementer. On each rising edge
//   with the write enable high the PC advances by STEP; a synchronous reset
//   returns it to RESET_VALUE and takes priority over the enable.
//
//   Interface: there is no handshake. The block is always ready; the enable
//   is sampled only at the rising clock edge and the output is the register
//   itself, so a new value appears exactly one edge after it is requested.
//
//   Ports
//     XLXN_2  in   1      clock, rising edge
//     XLXN_4  in   1      synchronous active-high reset
//     XLXN_3  in   1      PC write enable (1 = load PC+STEP)
//     XLXN_6  out  WIDTH  current PC (registered)
// ---------------------------------------------------------------------------
module pc_pc_adder
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH       = PC_WIDTH,
    parameter int unsigned      STEP        = PC_STEP,
    parameter logic [WIDTH-1:0] RESET_VALUE = PC_RESET_VECTOR
) (
    input  logic             XLXN_2,
    input  logic             XLXN_4,
    input  logic             XLXN_3,
    output logic [WIDTH-1:0] XLXN_6
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc;

    pc_adder #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_pc_adder (
        .a_i   (pc_q),
        .sum_o (pc_inc)
    );

    // Enable mux: advance when enabled, otherwise hold.
    always_comb begin
        pc_d = pc_q;
        if (XLXN_3) begin
            pc_d = pc_inc;
        end
    end

    // Reset sits outside the mux so it wins over the enable.
    always_ff @(posedge XLXN_2) begin
        if (XLXN_4) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign XLXN_6 = pc_q;

endmodule : pc_pc_adder

// File: tb/tb_pc_pc_adder.sv
// Bench for pc_pc_adder: directed sequences and random cycles, scoreboarded
// against a behavioural PC model.
module tb_pc_pc_adder;

    localparam int W = 16;

    // ------------------------------------------------------------ clock/reset
    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] pc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    pc_pc_adder dut (
        .XLXN_2 (clk),
        .XLXN_4 (rst),
        .XLXN_3 (en),
        .XLXN_6 (pc)
    );

    // ------------------------------------------------------------ scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_pc;
    int           n_checks;
    int           n_fail;

    task automatic check_val(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one rising edge.
    function automatic logic [W-1:0] next_pc(input logic [W-1:0] cur,
                                             input logic r, input logic e);
        if (r)      return 16'h0000;
        else if (e) return cur + 16'd2;
        else        return cur;
    endfunction

    // ------------------------------------------------------------ driver
    // Drive inputs at the falling edge (optionally wiggling the enable first
    // to show that only the edge value matters), push the expected PC, then
    // pop and compare just after the rising edge.
    task automatic drive_cycle(input logic r, input logic e, input bit glitch,
                               input string tag);
        logic [W-1:0] exp_v;
        @(negedge clk);
        if (glitch) begin
            rst = 1'b0;
            en  = ~e;
            #2;
        end
        rst      = r;
        en       = e;
        model_pc = next_pc(model_pc, r, e);
        exp_q.push_back(model_pc);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp_v = exp_q.pop_front();
            check_val(tag, pc, exp_v);
        end
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_pc = 'x;
        rst      = 1'b0;
        en       = 1'b0;

        // Reset, reset priority, hold
        drive_cycle(1'b1, 1'b0, 1'b0, "reset");
        check_val("reset_const", pc, 16'h0000);
        drive_cycle(1'b1, 1'b1, 1'b0, "reset_prio");
        check_val("reset_prio_const", pc, 16'h0000);
        drive_cycle(1'b0, 1'b0, 1'b0, "hold");
        check_val("hold_const", pc, 16'h0000);

        // Count 9 edges: 0x0002 .. 0x0012
        for (int i = 0; i < 9; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, "count");
        end
        check_val("count_end", pc, 16'h0012);

        // Mid-run reset at 0x0008 with enable high
        drive_cycle(1'b1, 1'b0, 1'b0, "mid_pre_reset");
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, "mid_count");
        end
        check_val("mid_at_8", pc, 16'h0008);
        drive_cycle(1'b1, 1'b1, 1'b0, "mid_reset");
        check_val("mid_reset_const", pc, 16'h0000);
        drive_cycle(1'b0, 1'b1, 1'b0, "mid_resume");
        check_val("mid_resume_const", pc, 16'h0002);

        // Enable wiggling between edges; only the edge value counts
        drive_cycle(1'b0, 1'b0, 1'b1, "glitch_hold");
        check_val("glitch_hold_const", pc, 16'h0002);
        drive_cycle(1'b0, 1'b1, 1'b1, "glitch_count");
        check_val("glitch_count_const", pc, 16'h0004);

        // Random enable/reset mix
        for (int i = 0; i < 300; i++) begin
            drive_cycle(($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                        $urandom_range(0, 1), "random");
        end

        // Wrap: count from 0 up to 0xFFFE, then across the top
        drive_cycle(1'b1, 1'b0, 1'b0, "wrap_reset");
        for (int i = 0; i < 32767; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, "wrap_count");
        end
        check_val("wrap_at_fffe", pc, 16'hFFFE);
        drive_cycle(1'b0, 1'b1, 1'b0, "wrap_edge");
        check_val("wrap_zero", pc, 16'h0000);
        drive_cycle(1'b0, 1'b1, 1'b0, "wrap_after");
        check_val("wrap_two", pc, 16'h0002);

        // Nothing may be left unconsumed in the scoreboard
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, want 0", exp_q.size());
        end

        // ------------------------------------------------------------ report
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_pc_adder
